// File: rtl/jk_cmd_seq.sv
// Command sequencer: queues {opcode, repeat} commands and plays each one out as
// registered J/K drive for repeat+1 cycles, tracking the downstream flip-flop's q.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [REP_W-1:0]         cmd_rep,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     done,
  output logic                     q_pred,
  output logic                     dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = REP_W + 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;
  logic              j_q, j_d;
  logic              k_q, k_d;
  logic              qp_q, qp_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       occ_q, occ_d;
  logic [EW-1:0]     mem [DEPTH];

  logic              push;
  logic              pop;
  logic              last;
  logic [EW-1:0]     head;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready never depends on cmd_valid.
  assign cmd_ready = reset && (occ_q < (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign last      = (state_q == RUN) && (cnt_q == '0);
  assign pop       = (occ_q != '0) && ((state_q == IDLE) || last);
  assign head      = mem[rd_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (pop) begin
          state_d    = RUN;
          cnt_d      = head[REP_W-1:0];
          {j_d, k_d} = head[EW-1:REP_W];
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pop) begin
          // Chain straight into the next command with no idle cycle.
          cnt_d      = head[REP_W-1:0];
          {j_d, k_d} = head[EW-1:REP_W];
        end else begin
          state_d = IDLE;
          j_d     = 1'b0;
          k_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    qp_d = qp_q;
    case ({j_q, k_q})
      2'b01:   qp_d = 1'b0;
      2'b10:   qp_d = 1'b1;
      2'b11:   qp_d = ~qp_q;
      default: qp_d = qp_q;
    endcase
  end

  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      qp_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      qp_q    <= qp_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {cmd_op, cmd_rep};
  end

  assign j         = j_q;
  assign k         = k_q;
  assign q_pred    = qp_q;
  assign done      = last;
  assign busy      = (state_q == RUN) || (occ_q != '0);
  assign dbg_state = state_q;
  assign dbg_occ   = occ_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq: hand-computed cycle checks plus an in-order
// scoreboard of accepted commands and an independent JK flip-flop model.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int REP_W = 4;
  localparam int EW    = REP_W + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [REP_W-1:0] cmd_rep = '0;
  logic             j, k, busy, done, q_pred, dbg_state;
  logic [2:0]       dbg_occ;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  int            cyc = 0;
  logic          qm = 1'b0;

  jk_cmd_seq #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_pred    (q_pred),
    .dbg_state (dbg_state),
    .dbg_occ   (dbg_occ)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [REP_W-1:0] rep);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rep   = rep;
    if (v && cmd_ready) exp_q.push_back({op, rep});
    step();
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic offer(input logic [1:0] op, input logic [REP_W-1:0] rep, output int waits);
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rep   = rep;
    while (!cmd_ready && waits < 64) begin
      step();
      waits++;
    end
    drive(1'b1, op, rep);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Downstream JK flip-flop driven by the DUT's j/k.
  always @(posedge clk or negedge reset) begin
    if (!reset) qm <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   qm <= 1'b0;
        2'b10:   qm <= 1'b1;
        2'b11:   qm <= ~qm;
        default: qm <= qm;
      endcase
    end
  end

  // Scoreboard: each done pulse retires the oldest accepted command.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            len;
    if (!reset) begin
      exp_q.delete();
      cyc = 0;
    end else begin
      chk("q_pred_vs_model", q_pred, qm);
      if (dbg_state) cyc++;
      if (done) begin
        chk("done_has_cmd", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          len = int'(e[REP_W-1:0]) + 1;
          chk("sb_op", {j, k}, e[EW-1:REP_W]);
          chk("sb_len", cyc, len);
        end
        cyc = 0;
      end
    end
  end

  initial begin
    int waits;

    // Reset state
    idle(2);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_q_pred", q_pred, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_occ", dbg_occ, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // Single set, rep=2
    drive(1'b1, 2'b10, 4'd2);
    chk("set_lat_j", j, 0);
    chk("set_lat_busy", busy, 1);
    chk("set_lat_occ", dbg_occ, 1);
    idle(1);
    chk("set_c1_j", j, 1);
    chk("set_c1_k", k, 0);
    chk("set_c1_done", done, 0);
    chk("set_c1_q", q_pred, 0);
    idle(1);
    chk("set_c2_j", j, 1);
    chk("set_c2_done", done, 0);
    chk("set_c2_q", q_pred, 1);
    idle(1);
    chk("set_c3_j", j, 1);
    chk("set_c3_k", k, 0);
    chk("set_c3_done", done, 1);
    idle(1);
    chk("set_end_j", j, 0);
    chk("set_end_k", k, 0);
    chk("set_end_busy", busy, 0);
    chk("set_end_done", done, 0);
    chk("set_end_q", q_pred, 1);

    // Back-to-back toggles, rep=0 x4
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 2'b11, 4'd0);
      else idle(1);
      if (i >= 1) begin
        chk("tog_j", j, 1);
        chk("tog_k", k, 1);
        chk("tog_done", done, 1);
        chk("tog_q", q_pred, (i == 1 || i == 3) ? 1 : 0);
        chk("tog_ready", cmd_ready, 1);
      end
    end
    idle(1);
    chk("tog_end_j", j, 0);
    chk("tog_end_busy", busy, 0);
    chk("tog_end_q", q_pred, 1);

    // Hold rep=1 after set
    drive(1'b1, 2'b10, 4'd0);
    drive(1'b1, 2'b00, 4'd1);
    chk("hs_set_j", j, 1);
    idle(1);
    chk("hold_c1_jk", {j, k}, 2'b00);
    chk("hold_c1_busy", busy, 1);
    chk("hold_c1_done", done, 0);
    chk("hold_c1_q", q_pred, 1);
    idle(1);
    chk("hold_c2_jk", {j, k}, 2'b00);
    chk("hold_c2_done", done, 1);
    chk("hold_c2_q", q_pred, 1);
    idle(1);
    chk("hold_end_busy", busy, 0);
    chk("hold_end_done", done, 0);

    // Push and pop on the same edge at occupancy 2
    drive(1'b1, 2'b01, 4'd3);
    drive(1'b1, 2'b10, 4'd0);
    drive(1'b1, 2'b11, 4'd0);
    idle(2);
    chk("pp_pre_occ", dbg_occ, 2);
    chk("pp_pre_done", done, 1);
    drive(1'b1, 2'b00, 4'd1);
    cmd_valid = 1'b0;
    chk("pp_occ", dbg_occ, 2);
    chk("pp_ready", cmd_ready, 1);
    chk("pp_jk", {j, k}, 2'b10);
    wait_idle();

    // Fill: one running, four queued, fifth held until a pop
    drive(1'b1, 2'b10, 4'd15);
    idle(1);
    drive(1'b1, 2'b01, 4'd15);
    drive(1'b1, 2'b11, 4'd15);
    drive(1'b1, 2'b00, 4'd15);
    drive(1'b1, 2'b10, 4'd15);
    chk("fill_occ", dbg_occ, 4);
    chk("fill_ready", cmd_ready, 0);
    offer(2'b01, 4'd15, waits);
    chk("fill_waits", waits, 12);
    chk("fill_occ_after", dbg_occ, 4);
    wait_idle();

    // Reset mid-RUN (set rep=7, third drive cycle) with one queued
    drive(1'b1, 2'b10, 4'd7);
    drive(1'b1, 2'b01, 4'd0);
    idle(2);
    chk("mr_pre_j", j, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_j", j, 0);
    chk("mr_k", k, 0);
    chk("mr_q", q_pred, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_ready", cmd_ready, 0);
    chk("mr_occ", dbg_occ, 0);
    chk("mr_state", dbg_state, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_jk", {j, k}, 2'b00);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end

    // First command after release is accepted immediately
    drive(1'b1, 2'b11, 4'd0);
    chk("first_occ", dbg_occ, 1);
    chk("first_busy", busy, 1);
    idle(1);
    chk("first_jk", {j, k}, 2'b11);
    chk("first_done", done, 1);
    idle(1);
    chk("first_end_busy", busy, 0);

    idle(1);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-002 SHALL provide parameter REP_W, default 4, width of per-command repeat field.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  upstream command present.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 hold, 01 clear (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1).
REQ-008 SHALL have port cmd_rep  input  REP_W  drive opcode for cmd_rep+1 consecutive cycles.
REQ-009 SHALL have port j  output  1  registered J drive to downstream JK flip-flop.
REQ-010 SHALL have port k  output  1  registered K drive to downstream JK flip-flop.
REQ-011 SHALL have port busy  output  1  engine executing or FIFO non-empty.
REQ-012 SHALL have port done  output  1  one-cycle pulse in final drive cycle of each command.
REQ-013 SHALL have port q_pred  output  1  predicted flip-flop q, for scoreboard cross-check.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_valid=1 with cmd_ready=0 leaves all state unchanged.
REQ-015 SHALL drive cmd_ready=1 iff FIFO occupancy < DEPTH and reset is deasserted.
REQ-016 SHALL store accepted {cmd_op, cmd_rep} in FIFO order; no reordering, no drop, no duplication.
REQ-017 SHALL implement engine FSM states IDLE and RUN, with a down-counter of width REP_W.
REQ-018 IDLE: j=k=0; on an edge with FIFO non-empty, pop head, load counter with cmd_rep, drive j/k per opcode, go RUN.
REQ-019 RUN: each edge with counter>0 decrements counter, j/k unchanged.
REQ-020 RUN with counter=0: done=1 that cycle; next edge pops next entry if FIFO non-empty (no idle gap), else go IDLE with j=k=0.
REQ-021 Latency: command accepted into empty FIFO with engine IDLE appears on j/k after the next rising edge (one cycle after acceptance edge).
REQ-022 Each command SHALL occupy exactly cmd_rep+1 cycles on j/k; cmd_rep=0 gives one cycle; cmd_rep=all-ones gives 2^REP_W cycles.
REQ-023 Simultaneous push and pop on one edge SHALL leave occupancy unchanged; push when full is impossible because cmd_ready=0.
REQ-024 Pop from empty FIFO SHALL never occur; read/write pointers wrap modulo DEPTH.
REQ-025 q_pred SHALL update each edge from the current j/k: 00 hold, 01 -> 0, 10 -> 1, 11 -> invert.
REQ-026 busy SHALL be 1 iff state=RUN or occupancy>0.
REQ-027 done SHALL be high for exactly one cycle per executed command, including hold (00) commands.

Reset
REQ-028 Asserting reset (low) SHALL immediately, without waiting for clk, force j=0, k=0, q_pred=0, done=0, busy=0, cmd_ready=0, state=IDLE, counter=0 and FIFO empty.
REQ-029 Reset asserted mid-command SHALL discard the executing command and all queued commands; none resume after release.
REQ-030 After reset release, cmd_ready SHALL be 1, and the first command SHALL be accepted on the first rising edge where cmd_valid=1.

Verification
REQ-031 Single set, rep=2: j/k=10 for 3 cycles starting one cycle after acceptance, done on 3rd cycle, q_pred 0->1, then j=k=0 and busy=0.
REQ-032 Back-to-back toggle rep=0 x4: four consecutive cycles of j/k=11 with no gap, done high all four cycles, q_pred 1,0,1,0.
REQ-033 Fill: five commands rep=15 offered while engine busy: cmd_ready drops after 4 queued, 5th held until a pop, all execute in order.
REQ-034 Push and pop on same edge with occupancy 2: occupancy stays 2, cmd_ready stays 1.
REQ-035 Reset asserted mid-RUN (set, rep=7, cycle 3): j=k=0, q_pred=0, busy=0 asynchronously; after release no residual drive.
REQ-036 Hold command rep=1 after set: j/k=00 for 2 cycles, q_pred stays 1, done in 2nd cycle; q_pred matches DUT q throughout.
